// File: rtl/gpio_serial_port_p.sv
// gpio_serial_port_p
//   Half-duplex serial GPIO engine with UART-style framing. A frame is one
//   start bit (0), DWIDTH data bits in a selectable order, and one stop bit (1).
//   Every bit lasts cfg_div+1 rclk cycles.
//   The transmit side takes words from the TX FIFO read side through a
//   valid/ready handshake. The receive side finds a start edge on the
//   synchronised gpio_in, samples each bit near its centre, and writes good
//   words to the RX FIFO through a one-cycle rx_valid pulse.
//
// Ports
//   rclk, rrst_n      clock; asynchronous active-low reset
//   cfg_dir           1 = transmit, 0 = receive (sampled only in IDLE)
//   cfg_div           bit period minus one (captured at frame start)
//   cfg_msb_first     bit order (captured at frame start)
//   tx_data/valid     word offered for transmission
//   tx_ready          word accepted on this cycle's edge when tx_valid is high
//   serial_out/oe     registered pad data / output enable
//   gpio_in           asynchronous serial input
//   rx_data           last correctly framed received word
//   rx_valid          one-cycle pulse when rx_data updates
//   rx_frame_err      one-cycle pulse when a stop bit is sampled low
//   busy              FSM is not idle
module gpio_serial_port_p #(
  parameter int DWIDTH      = 8,
  parameter int DIV_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              cfg_dir,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_msb_first,
  input  logic [DWIDTH-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              serial_out,
  output logic              serial_oe,
  input  logic              gpio_in,
  output logic [DWIDTH-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_frame_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DWIDTH + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_TX_START = 3'd1;
  localparam logic [2:0] S_TX_DATA  = 3'd2;
  localparam logic [2:0] S_TX_STOP  = 3'd3;
  localparam logic [2:0] S_RX_START = 3'd4;
  localparam logic [2:0] S_RX_DATA  = 3'd5;
  localparam logic [2:0] S_RX_STOP  = 3'd6;

  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DWIDTH - 1);
  localparam logic [DIV_W-1:0] TMR_ONE  = DIV_W'(1);

  // ---------------------------------------------------------------------------
  // Input synchroniser. Flops reset to 1 (idle line level) so that reset
  // release never looks like a start edge.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   line;

  assign line = sync_q[SYNC_STAGES-1];

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
      prev_q <= line;
    end
  end

  // ---------------------------------------------------------------------------
  // Bit-order helpers. The shifter is shared by TX (shift out) and RX
  // (shift in); the engine is half-duplex so they never overlap.
  // ---------------------------------------------------------------------------
  function automatic logic head_bit(input logic [DWIDTH-1:0] w, input logic msb);
    return msb ? w[DWIDTH-1] : w[0];
  endfunction

  function automatic logic [DWIDTH-1:0] shift_out(input logic [DWIDTH-1:0] w,
                                                  input logic msb);
    return msb ? (w << 1) : (w >> 1);
  endfunction

  // LSB-first: new bits enter at the top so the first bit ends up at bit 0.
  // MSB-first: new bits enter at the bottom so the first bit ends up on top.
  function automatic logic [DWIDTH-1:0] shift_in(input logic [DWIDTH-1:0] w,
                                                 input logic msb,
                                                 input logic b);
    return msb ? ((w << 1) | DWIDTH'(b))
               : ((w >> 1) | (DWIDTH'(b) << (DWIDTH - 1)));
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]        state_q, state_d;
  logic [DIV_W-1:0]  timer_q, timer_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              msb_q, msb_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DWIDTH-1:0] shift_q, shift_d;
  logic              sout_q, sout_d;
  logic              soe_q, soe_d;
  logic [DWIDTH-1:0] rxd_q, rxd_d;
  logic              rxv_q, rxv_d;
  logic              rxe_q, rxe_d;
  // Low for the reset cycles only; keeps tx_ready low while in reset even
  // though cfg_dir may already be high.
  logic              run_q;

  logic tick;
  assign tick = (timer_q == '0);

  assign tx_ready     = run_q && (state_q == S_IDLE) && cfg_dir;
  assign busy         = (state_q != S_IDLE);
  assign serial_out   = sout_q;
  assign serial_oe    = soe_q;
  assign rx_data      = rxd_q;
  assign rx_valid     = rxv_q;
  assign rx_frame_err = rxe_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    div_d   = div_q;
    msb_d   = msb_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    sout_d  = sout_q;
    soe_d   = soe_q;
    rxd_d   = rxd_q;
    rxv_d   = 1'b0;
    rxe_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        soe_d  = cfg_dir;
        sout_d = 1'b1;
        if (tx_valid && tx_ready) begin
          shift_d = tx_data;
          div_d   = cfg_div;
          msb_d   = cfg_msb_first;
          timer_d = cfg_div;
          sout_d  = 1'b0;
          state_d = S_TX_START;
        end else if (!cfg_dir && prev_q && !line) begin
          // Half a bit period to land the start sample mid-bit.
          div_d   = cfg_div;
          msb_d   = cfg_msb_first;
          timer_d = cfg_div >> 1;
          idx_d   = '0;
          state_d = S_RX_START;
        end
      end

      S_TX_START: begin
        if (tick) begin
          sout_d  = head_bit(shift_q, msb_q);
          shift_d = shift_out(shift_q, msb_q);
          timer_d = div_q;
          idx_d   = '0;
          state_d = S_TX_DATA;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end

      S_TX_DATA: begin
        if (tick) begin
          timer_d = div_q;
          if (idx_q == IDX_LAST) begin
            sout_d  = 1'b1;
            state_d = S_TX_STOP;
          end else begin
            sout_d  = head_bit(shift_q, msb_q);
            shift_d = shift_out(shift_q, msb_q);
            idx_d   = idx_q + IDX_ONE;
          end
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end

      S_TX_STOP: begin
        if (tick) state_d = S_IDLE;
        else      timer_d = timer_q - TMR_ONE;
      end

      S_RX_START: begin
        if (tick) begin
          if (line) begin
            // Line back high mid start bit: glitch, not a frame.
            state_d = S_IDLE;
          end else begin
            timer_d = div_q;
            idx_d   = '0;
            state_d = S_RX_DATA;
          end
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end

      S_RX_DATA: begin
        if (tick) begin
          shift_d = shift_in(shift_q, msb_q, line);
          timer_d = div_q;
          if (idx_q == IDX_LAST) state_d = S_RX_STOP;
          else                   idx_d   = idx_q + IDX_ONE;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end

      S_RX_STOP: begin
        if (tick) begin
          if (line) begin
            rxd_d = shift_q;
            rxv_d = 1'b1;
          end else begin
            rxe_d = 1'b1;
          end
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      div_q   <= '0;
      msb_q   <= 1'b0;
      idx_q   <= '0;
      shift_q <= '0;
      sout_q  <= 1'b1;
      soe_q   <= 1'b0;
      rxd_q   <= '0;
      rxv_q   <= 1'b0;
      rxe_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      div_q   <= div_d;
      msb_q   <= msb_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      sout_q  <= sout_d;
      soe_q   <= soe_d;
      rxd_q   <= rxd_d;
      rxv_q   <= rxv_d;
      rxe_q   <= rxe_d;
      run_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gpio_serial_port_p.sv
// Bench for gpio_serial_port_p: one instance used as transmitter, one as
// receiver. The receiver input is either driven directly or looped back from
// the transmitter's serial_out.
module tb_gpio_serial_port_p;

  logic       rclk;
  logic       rst_tx_n, rst_rx_n;
  logic [7:0] cfg_div;
  logic       msb;
  logic       tx_dir, rx_dir;
  logic [7:0] tx_data, rx_txd;
  logic       tx_valid, rx_txv;
  logic       rx_line, loop_en, tx_gpio;
  logic       rx_gpio;

  logic       t_ready, t_sout, t_soe, t_busy, t_rxv, t_rxe;
  logic [7:0] t_rxd;
  logic       r_ready, r_sout, r_soe, r_busy, r_rxv, r_rxe;
  logic [7:0] r_rxd;

  int n_chk = 0;
  int n_err = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic [7:0] words[$];

  assign rx_gpio = loop_en ? t_sout : rx_line;

  gpio_serial_port_p #(.DWIDTH(8), .DIV_W(8), .SYNC_STAGES(2)) u_tx (
    .rclk(rclk), .rrst_n(rst_tx_n), .cfg_dir(tx_dir), .cfg_div(cfg_div),
    .cfg_msb_first(msb), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(t_ready), .serial_out(t_sout), .serial_oe(t_soe),
    .gpio_in(tx_gpio), .rx_data(t_rxd), .rx_valid(t_rxv),
    .rx_frame_err(t_rxe), .busy(t_busy)
  );

  gpio_serial_port_p #(.DWIDTH(8), .DIV_W(8), .SYNC_STAGES(2)) u_rx (
    .rclk(rclk), .rrst_n(rst_rx_n), .cfg_dir(rx_dir), .cfg_div(cfg_div),
    .cfg_msb_first(msb), .tx_data(rx_txd), .tx_valid(rx_txv),
    .tx_ready(r_ready), .serial_out(r_sout), .serial_oe(r_soe),
    .gpio_in(rx_gpio), .rx_data(r_rxd), .rx_valid(r_rxv),
    .rx_frame_err(r_rxe), .busy(r_busy)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // Receiver monitor: record every reported word and frame error.
  always @(negedge rclk) begin
    if (r_rxv) words.push_back(r_rxd);
    if (r_rxe) err_cnt++;
    if (r_rxv && r_rxe) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected line level in frame slot s (0 = start, 1..8 data, 9 = stop).
  function automatic logic fbit(input logic [7:0] w, input logic m, input int s);
    if (s == 0) return 1'b0;
    if (s == 9) return 1'b1;
    return m ? w[8 - s] : w[s - 1];
  endfunction

  // Offer one word, then check every cycle of the frame. With tog set, cfg_dir
  // drops mid-frame; the frame must still complete and serial_oe must only
  // follow once the engine is idle again.
  task automatic tx_frame(input logic [7:0] w, input logic m, input logic [7:0] d,
                          input bit tog);
    int p;
    int tot;
    p   = int'(d) + 1;
    tot = 10 * p;
    @(negedge rclk);
    cfg_div = d; msb = m; tx_data = w; tx_valid = 1'b1; tx_dir = 1'b1;
    #1 chk($sformatf("tx_ready_pre_%0h", w), t_ready, 1);
    @(negedge rclk);
    tx_valid = 1'b0;
    tx_data  = ~w;
    for (int k = 0; k < tot; k++) begin
      if (tog && k == p) tx_dir = 1'b0;
      chk($sformatf("sout_%0h_k%0d", w, k), t_sout, fbit(w, m, k / p));
      chk($sformatf("tx_ready_busy_%0h_k%0d", w, k), t_ready, 0);
      chk($sformatf("soe_frame_%0h_k%0d", w, k), t_soe, 1);
      @(negedge rclk);
    end
    chk($sformatf("tx_ready_post_%0h", w), t_ready, tog ? 0 : 1);
    chk($sformatf("tx_idle_%0h", w), t_busy, 0);
    if (tog) begin
      chk("soe_hold_idle", t_soe, 1);
      @(negedge rclk);
      chk("soe_after_idle", t_soe, 0);
      tx_dir = 1'b1;
      @(negedge rclk);
    end
  endtask

  // Drive nslots frame slots directly onto the receiver line, 8 cycles each.
  task automatic rx_send(input logic [7:0] w, input logic m, input logic stopb,
                         input int nslots);
    @(negedge rclk);
    msb = m;
    for (int s = 0; s < nslots; s++) begin
      rx_line = (s == 9) ? stopb : fbit(w, m, s);
      repeat (8) @(negedge rclk);
    end
    rx_line = 1'b1;
  endtask

  int base;
  int e0;

  initial begin
    rst_tx_n = 1'b0; rst_rx_n = 1'b0;
    cfg_div = 8'd3; msb = 1'b0;
    tx_dir = 1'b1; rx_dir = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0;
    rx_txd = 8'h00; rx_txv = 1'b0;
    rx_line = 1'b1; loop_en = 1'b0; tx_gpio = 1'b1;

    // Reset held with the input toggling.
    for (int i = 0; i < 6; i++) begin
      @(negedge rclk);
      rx_line = ~rx_line;
      chk($sformatf("rst_sout_%0d", i), t_sout, 1);
      chk($sformatf("rst_ready_%0d", i), t_ready, 0);
      chk($sformatf("rst_busy_%0d", i), t_busy | r_busy, 0);
      chk($sformatf("rst_soe_%0d", i), t_soe, 0);
      chk($sformatf("rst_rxv_%0d", i), r_rxv, 0);
      chk($sformatf("rst_rxd_%0d", i), r_rxd, 0);
    end
    rx_line = 1'b1;
    @(negedge rclk);
    rst_tx_n = 1'b1; rst_rx_n = 1'b1;
    repeat (3) @(negedge rclk);
    chk("idle_soe", t_soe, 1);

    // Transmit framing, both bit orders, plus one-cycle bits.
    tx_frame(8'hA5, 1'b0, 8'd3, 1'b0);
    tx_frame(8'hA5, 1'b1, 8'd3, 1'b0);
    tx_frame(8'h01, 1'b1, 8'd3, 1'b0);
    tx_frame(8'h3C, 1'b0, 8'd0, 1'b0);
    chk("rx_quiet_during_tx", words.size(), 0);

    // Loopback at cfg_div=7.
    loop_en = 1'b1;
    base = words.size();
    e0   = err_cnt;
    tx_frame(8'h00, 1'b0, 8'd7, 1'b0);
    tx_frame(8'hFF, 1'b0, 8'd7, 1'b0);
    tx_frame(8'h3C, 1'b0, 8'd7, 1'b0);
    repeat (20) @(negedge rclk);
    loop_en = 1'b0;
    chk("loop_count", words.size() - base, 3);
    if (words.size() >= base + 3) begin
      chk("loop_w0", words[base], 8'h00);
      chk("loop_w1", words[base + 1], 8'hFF);
      chk("loop_w2", words[base + 2], 8'h3C);
    end
    chk("loop_no_err", err_cnt - e0, 0);

    // Stop bit forced low, then a good MSB-first frame.
    cfg_div = 8'd7;
    base = words.size();
    e0   = err_cnt;
    rx_send(8'h55, 1'b0, 1'b0, 10);
    repeat (20) @(negedge rclk);
    chk("ferr_count", err_cnt - e0, 1);
    chk("ferr_no_valid", words.size() - base, 0);
    chk("ferr_rxd_kept", r_rxd, 8'h3C);
    rx_send(8'h12, 1'b1, 1'b1, 10);
    repeat (20) @(negedge rclk);
    chk("good_after_ferr_cnt", words.size() - base, 1);
    if (words.size() > base) chk("good_after_ferr_w", words[base], 8'h12);
    chk("good_after_ferr_rxd", r_rxd, 8'h12);
    chk("good_after_ferr_err", err_cnt - e0, 1);

    // One-cycle glitch: false start.
    base = words.size();
    e0   = err_cnt;
    @(negedge rclk);
    rx_line = 1'b0;
    @(negedge rclk);
    rx_line = 1'b1;
    repeat (3) @(negedge rclk);
    chk("glitch_busy", r_busy, 1);
    repeat (10) @(negedge rclk);
    chk("glitch_idle", r_busy, 0);
    chk("glitch_no_valid", words.size() - base, 0);
    chk("glitch_no_err", err_cnt - e0, 0);

    // Reset mid-receive after start + 4 data bits, then a full frame.
    base = words.size();
    e0   = err_cnt;
    rx_send(8'h65, 1'b0, 1'b1, 5);
    chk("midrx_busy", r_busy, 1);
    rst_rx_n = 1'b0;
    @(negedge rclk);
    chk("midrx_rst_busy", r_busy, 0);
    chk("midrx_rst_rxd", r_rxd, 0);
    repeat (2) @(negedge rclk);
    rst_rx_n = 1'b1;
    repeat (4) @(negedge rclk);
    rx_send(8'h9A, 1'b0, 1'b1, 10);
    repeat (20) @(negedge rclk);
    chk("midrx_count", words.size() - base, 1);
    if (words.size() > base) chk("midrx_word", words[base], 8'h9A);
    chk("midrx_no_err", err_cnt - e0, 0);

    // cfg_dir dropped mid-transmit.
    tx_frame(8'hC3, 1'b0, 8'd3, 1'b1);

    chk("valid_err_exclusive", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/gpio_serial_port_p.md
Name: gpio_serial_port_p

Overview:
Parametrised serial GPIO engine for the rclk domain. It replaces the fixed 8-bit, one-bit-per-clock shifter with UART-style framing: a start bit, DWIDTH data bits, and a stop bit. Bit rate is programmable, and bit order is selectable (LSB- or MSB-first). The transmit side uses a valid/ready handshake. The receive side uses start-bit detection with a metastability synchroniser and reports frame errors. It sits between the TX async FIFO read side and the RX async FIFO write side.

Parameters:
DWIDTH, 8, data bits per frame (legal range 1 to 32).
DIV_W, 8, width of the bit-period divider field.
SYNC_STAGES, 2, number of synchroniser flops on gpio_in (minimum 2).

Ports:
rclk  in  1  clock.
rrst_n  in  1  reset: asynchronous, active-low.
cfg_dir  in  1  1 = transmit, 0 = receive. Sampled only in IDLE.
cfg_div  in  DIV_W  bit period = cfg_div+1 rclk cycles. Captured at frame start.
cfg_msb_first  in  1  1 = MSB first, 0 = LSB first. Captured at frame start.
tx_data  in  DWIDTH  word to transmit.
tx_valid  in  1  tx_data is valid.
tx_ready  out  1  engine accepts a word this cycle.
serial_out  out  1  registered serial line; idles high.
serial_oe  out  1  registered pad output enable; equals cfg_dir as sampled in IDLE.
gpio_in  in  1  asynchronous serial input.
rx_data  out  DWIDTH  last correctly framed received word.
rx_valid  out  1  one-cycle pulse when rx_data updates (drives RX FIFO winc).
rx_frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: serial_out=1, serial_oe=0, tx_ready=0, rx_data=0, rx_valid=0, rx_frame_err=0, busy=0, all synchroniser flops=1, FSM=IDLE.
- FSM states: IDLE, TX_START, TX_DATA, TX_STOP, RX_START, RX_DATA, RX_STOP.
- Timing uses a DIV_W-bit down-counter (bit timer) and a bit index counter of width clog2(DWIDTH+1).
- IDLE:
  - serial_oe is registered from cfg_dir every cycle.
  - tx_ready = (cfg_dir==1), combinational from state and cfg_dir.
  - If tx_valid && tx_ready: load the shifter, capture cfg_div and cfg_msb_first, go to TX_START.
  - If cfg_dir==0 and the synchronised input shows a 1->0 edge (previous sync value 1, current 0): go to RX_START with timer = cfg_div>>1.
- TX:
  - serial_out=0 from the cycle after acceptance, held cfg_div+1 cycles.
  - TX_DATA then drives DWIDTH bits, each held cfg_div+1 cycles, in the captured order.
  - TX_STOP drives 1 for cfg_div+1 cycles, then returns to IDLE.
  - Total: tx_ready is next high exactly (DWIDTH+2)*(cfg_div+1) cycles after the accept edge.
  - tx_data changes after acceptance have no effect.
  - tx_valid is ignored when cfg_dir==0.
- RX:
  - In RX_START, sample the synchronised line when the timer expires (mid start bit).
  - If the sample is 1, it is a false start: return to IDLE with no pulse.
  - Otherwise reload timer = cfg_div and sample each data bit every cfg_div+1 cycles.
  - Assemble bits into rx_data in the captured bit order.
  - Sample the stop bit. If 1: update rx_data and pulse rx_valid on the next cycle. If 0: pulse rx_frame_err, leave rx_data unchanged.
  - Return to IDLE; a new start requires a fresh 1->0 edge.
- Mode and config:
  - cfg_dir, cfg_div and cfg_msb_first changes mid-frame are ignored until IDLE.
  - The engine is half-duplex: RX edges are ignored while transmitting.
- cfg_div=0: one cycle per bit. The RX start sample is taken the cycle after edge detection.
- Reset mid-frame: everything returns to reset values immediately; a partial RX word is discarded and never signalled.
- Input latency: gpio_in reaches the FSM after SYNC_STAGES cycles.
- rx_valid and rx_frame_err are never high in the same cycle.

Test Plan:
- Reset held, gpio_in toggling -> serial_out=1, rx_valid=0, tx_ready=0, busy=0 throughout.
- cfg_dir=1, cfg_div=3, LSB-first, tx_data=0xA5 -> serial_out shows 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles; tx_ready returns high exactly 40 cycles after the accept edge. Repeat MSB-first -> bits 1,0,1,0,0,1,0,1 (0xA5 is a palindrome); then 0x01 MSB-first -> seven 0s, then a 1.
- Loopback (serial_out to gpio_in, one instance TX, one RX), cfg_div=7, words 0x00, 0xFF, 0x3C -> three rx_valid pulses with rx_data equal to each word in order; no rx_frame_err.
- RX frame with stop bit forced 0, data 0x55 -> rx_frame_err pulses once, rx_valid stays 0, rx_data keeps its previous value; the next good frame 0x12 is received correctly.
- Glitch on gpio_in: low for 1 cycle, cfg_div=7 -> false start; no pulse; FSM back in IDLE.
- Reset asserted mid-RX after 4 bits, then a full frame 0x9A -> only 0x9A is reported. Also: toggle cfg_dir mid-TX -> the frame completes unchanged; serial_oe updates only after return to IDLE.
